// File: rtl/la_capture_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : la_capture_wb_if
// Description : Wishbone slave-side signal bundle for the LA capture block.
//               slave  modport: strobe/cycle/we/sel/data/address in,
//                               ack/read data out.
//               master modport: the mirror image, for the bus owner.
// Revision    : 1.0 - initial release
// ============================================================================
interface la_capture_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/la_capture_wb.sv
`default_nettype none
// ============================================================================
// Module      : la_capture_wb
// Description : Inbound logic-analyzer block on the Wishbone bus. Routes
//               la_data_in to the selected team slot (1-cycle registered) and
//               captures 128-bit samples into a FIFO that firmware drains as
//               four 32-bit DATA words (a DATA3 read pops the head).
// Ports       : wb_clk_i / wb_rst_i  - clock, synchronous active-high reset
//               wb (slave modport)   - Wishbone slave signals
//               la_data_in           - 128-bit LA data from management core
//               designs_la_data_in_flat - per-team LA input, slot k at
//                                      [128k+127:128k]
//               IRQ                  - interrupt level
// Options     : define LA_CAPTURE_IRQ_EN to build the IRQ logic; otherwise
//               IRQ is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module la_capture_wb #(
    parameter int NUM_TEAMS  = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    la_capture_wb_if.slave                wb,
    input  logic [127:0]                  la_data_in,
    output logic [128*(NUM_TEAMS+1)-1:0]  designs_la_data_in_flat,
    output logic                          IRQ
);

    localparam int c_SLOTS = NUM_TEAMS + 1;
    localparam int c_SEL_W = $clog2(c_SLOTS);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic                   r_ack;
    logic [c_SEL_W-1:0]     r_sel;
    logic                   r_cont;
    logic [DIV_WIDTH-1:0]   r_div;
    state_t                 r_state;
    logic [DIV_WIDTH-1:0]   r_smp_cnt;
    logic [127:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_ovf;
    logic [128*c_SLOTS-1:0] r_flat;

    logic        w_req, w_wr, w_rd, w_ctrl_wr, w_arm, w_flush;
    logic [2:0]  w_addr;
    logic        w_empty, w_full, w_pop, w_tick, w_push, w_drop;
    logic [7:0]  w_count8;
    logic [127:0] w_head;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Bus accesses take effect in the cycle the registered ack is high.
    assign w_req     = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign w_addr    = wb.wbs_adr_i[4:2];
    assign w_wr      = r_ack & w_req & wb.wbs_we_i;
    assign w_rd      = r_ack & w_req & ~wb.wbs_we_i;
    assign w_ctrl_wr = w_wr && (w_addr == 3'd1) && wb.wbs_sel_i[0];
    assign w_arm     = w_ctrl_wr & wb.wbs_dat_i[0];
    assign w_flush   = w_ctrl_wr & wb.wbs_dat_i[2];

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop    = w_rd && (w_addr == 3'd7) && !w_empty;
    assign w_tick   = (r_state == S_CAPTURE) && (r_smp_cnt == r_div);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push   = w_tick && (!w_full || w_pop);
    assign w_drop   = w_tick && w_full && !w_pop;
    assign w_count8 = 8'(r_count);
    assign w_head   = r_mem[r_rd_ptr];

    assign w_unused = ^{wb.wbs_adr_i[31:5], wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:16]};

    // Handshake and configuration registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack  <= 1'b0;
            r_sel  <= '0;
            r_cont <= 1'b0;
            r_div  <= '0;
        end else begin
            r_ack <= w_req & ~r_ack;
            if (w_wr && (w_addr == 3'd0) && wb.wbs_sel_i[0])
                r_sel <= wb.wbs_dat_i[c_SEL_W-1:0];
            if (w_ctrl_wr)
                r_cont <= wb.wbs_dat_i[1];
            if (w_wr && (w_addr == 3'd3)) begin
                for (int b = 0; b < DIV_WIDTH; b++)
                    if (wb.wbs_sel_i[b/8])
                        r_div[b] <= wb.wbs_dat_i[b];
            end
        end
    end

    // Capture FSM; FLUSH overrides everything else.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_smp_cnt <= '0;
        end else if (w_flush) begin
            r_state   <= S_IDLE;
            r_smp_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_arm) begin
                        r_state   <= S_CAPTURE;
                        r_smp_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_smp_cnt <= w_tick ? '0 : r_smp_cnt + 1'b1;
                    // One-shot ends on the push that fills the FIFO.
                    if (w_push && !r_cont && !w_pop &&
                        (r_count == c_CNT_W'(FIFO_DEPTH - 1)))
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture FIFO
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= la_data_in;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    // Team routing: one registered copy per slot, out-of-range SEL matches none.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_flat <= '0;
        end else begin
            for (int k = 0; k < c_SLOTS; k++)
                r_flat[128*k +: 128] <= (r_sel == c_SEL_W'(k)) ? la_data_in : 128'd0;
        end
    end
    assign designs_la_data_in_flat = r_flat;

    // Read data mux
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            3'd0: w_rdata[c_SEL_W-1:0] = r_sel;
            3'd1: w_rdata[1] = r_cont;
            3'd2: w_rdata = {16'h0, w_count8, 2'b00, r_state, 1'b0, r_ovf, w_full, w_empty};
            3'd3: w_rdata[DIV_WIDTH-1:0] = r_div;
            default: begin
                if (!w_empty)
                    w_rdata = w_head[{w_addr[1:0], 5'd0} +: 32];
            end
        endcase
    end

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = w_rd ? w_rdata : 32'd0;

`ifdef LA_CAPTURE_IRQ_EN
    logic r_irq;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            r_irq <= 1'b0;
        else
            r_irq <= (r_state == S_DONE) || r_ovf;
    end
    assign IRQ = r_irq;
`else
    assign IRQ = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_la_capture_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_capture_wb
// Description : Self-checking bench for la_capture_wb: a register vector
//               table plus hand-timed capture sequences (routing, one-shot,
//               sample period, pop/push on full, overflow, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_capture_wb;
    localparam int c_SLOTS = 13;
`ifdef LA_CAPTURE_IRQ_EN
    localparam logic c_IRQ_ON = 1'b1;
`else
    localparam logic c_IRQ_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [127:0]           la_data_in = '0;
    logic [128*c_SLOTS-1:0] flat;
    logic                   irq;

    int n_vec = 0;
    int n_bad = 0;

    la_capture_wb_if wb();

    la_capture_wb #(.NUM_TEAMS(12), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
        .wb_clk_i               (clk),
        .wb_rst_i               (rst),
        .wb                     (wb),
        .la_data_in             (la_data_in),
        .designs_la_data_in_flat(flat),
        .IRQ                    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus transfer; starts #1 after an edge, ack expected on the next
    // edge, commit on the one after, returns #1 after the commit edge.
    task automatic wb_xfer(input logic we, input logic [2:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, output logic [31:0] rdata);
        logic got;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = {27'd0, addr, 2'b00};
        wb.wbs_dat_i = data;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack, expected ack within 4 cycles");
        end
        rdata = wb.wbs_dat_o;
        @(posedge clk);
        #1;
        chk("ack_one_cycle", {127'd0, wb.wbs_ack_o}, 128'd0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_dat_i = 32'd0;
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [31:0] data);
        logic [31:0] d;
        wb_xfer(1'b1, addr, 4'hF, data, d);
    endtask

    task automatic wb_read(input string name, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, addr, 4'hF, 32'd0, d);
        chk(name, {96'd0, d}, {96'd0, exp});
    endtask

    function automatic logic [127:0] pat(input logic [31:0] base, input int n);
        return {32'h3000_0000 + n, 32'h2000_0000 + n, 32'h1000_0000 + n, base + n};
    endfunction

    initial begin
        logic [31:0] rd;
        logic [127:0] a5;

        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_dat_i = 32'd0;
        wb.wbs_adr_i = 32'd0;

        // Register vectors: we, addr, sel, wdata, expected read data
        vecs[0]  = '{1'b0, 3'd2, 4'hF, 32'h0,         32'h0000_0001};
        vecs[1]  = '{1'b0, 3'd0, 4'hF, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 3'd3, 4'hF, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 3'd1, 4'hF, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 3'd0, 4'hF, 32'h5,         32'h0};
        vecs[5]  = '{1'b0, 3'd0, 4'hF, 32'h0,         32'h5};
        vecs[6]  = '{1'b1, 3'd0, 4'h0, 32'hA,         32'h0};
        vecs[7]  = '{1'b0, 3'd0, 4'hF, 32'h0,         32'h5};
        vecs[8]  = '{1'b1, 3'd3, 4'h1, 32'h1234,      32'h0};
        vecs[9]  = '{1'b0, 3'd3, 4'hF, 32'h0,         32'h34};
        vecs[10] = '{1'b1, 3'd3, 4'h2, 32'hAB00,      32'h0};
        vecs[11] = '{1'b0, 3'd3, 4'hF, 32'h0,         32'hAB34};
        vecs[12] = '{1'b1, 3'd3, 4'hC, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{1'b0, 3'd3, 4'hF, 32'h0,         32'hAB34};
        vecs[14] = '{1'b1, 3'd1, 4'hF, 32'h2,         32'h0};
        vecs[15] = '{1'b0, 3'd1, 4'hF, 32'h0,         32'h2};
        vecs[16] = '{1'b1, 3'd1, 4'hF, 32'h0,         32'h0};
        vecs[17] = '{1'b0, 3'd1, 4'hF, 32'h0,         32'h0};
        vecs[18] = '{1'b0, 3'd4, 4'hF, 32'h0,         32'h0};
        vecs[19] = '{1'b0, 3'd7, 4'hF, 32'h0,         32'h0};
        vecs[20] = '{1'b0, 3'd2, 4'hF, 32'h0,         32'h0000_0001};
        vecs[21] = '{1'b1, 3'd3, 4'hF, 32'h0,         32'h0};
        vecs[22] = '{1'b1, 3'd0, 4'hF, 32'h0,         32'h0};

        // Reset state, with live LA data that must not leak through
        la_data_in = '1;
        idle(3);
        chk("rst_flat_zero", {127'd0, (flat == '0)}, 128'd1);
        chk("rst_ack", {127'd0, wb.wbs_ack_o}, 128'd0);
        chk("rst_dat_o", {96'd0, wb.wbs_dat_o}, 128'd0);
        chk("rst_irq", {127'd0, irq}, 128'd0);
        la_data_in = '0;
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 23; i++) begin
            wb_xfer(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, rd);
            if (!vecs[i].we)
                chk($sformatf("vec%0d", i), {96'd0, rd}, {96'd0, vecs[i].exp});
        end

        // Routing to slot 3, then out-of-range SEL
        a5 = {16{8'hA5}};
        la_data_in = a5;
        wb_write(3'd0, 32'd3);
        idle(1);
        for (int k = 0; k < c_SLOTS; k++)
            chk($sformatf("route_slot%0d", k), flat[128*k +: 128], (k == 3) ? a5 : 128'd0);
        la_data_in = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        chk("route_before_edge", flat[3*128 +: 128], a5);
        idle(1);
        chk("route_one_cycle", flat[3*128 +: 128], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        wb_write(3'd0, 32'd13);
        idle(1);
        for (int k = 0; k < c_SLOTS; k++)
            chk($sformatf("sel13_slot%0d", k), flat[128*k +: 128], 128'd0);
        wb_write(3'd0, 32'd0);

        // One-shot, DIV=0: samples 100..107 captured, then DONE
        wb_write(3'd1, 32'h1);
        for (int n = 0; n < 12; n++) begin
            la_data_in = pat(32'd100, n);
            idle(1);
        end
        wb_read("oneshot_status", 3'd2, 32'h0000_0822);
        chk("oneshot_irq", {127'd0, irq}, {127'd0, c_IRQ_ON});
        for (int i = 0; i < 8; i++) begin
            wb_read($sformatf("oneshot_d0_%0d", i), 3'd4, 32'd100 + i);
            wb_read($sformatf("oneshot_d1_%0d", i), 3'd5, 32'h1000_0000 + i);
            wb_read($sformatf("oneshot_d3_%0d", i), 3'd7, 32'h3000_0000 + i);
        end
        wb_read("drained_status", 3'd2, 32'h0000_0021);
        wb_write(3'd1, 32'h4);
        idle(2);
        chk("flush_irq", {127'd0, irq}, 128'd0);
        wb_read("flush_status", 3'd2, 32'h0000_0001);

        // DIV=3: push on the 4th cycle after entry, then every 4 cycles
        wb_write(3'd3, 32'd3);
        wb_write(3'd1, 32'h1);
        wb_read("div3_t1", 3'd2, 32'h0000_0011);
        wb_read("div3_t3", 3'd2, 32'h0000_0011);
        wb_read("div3_t5", 3'd2, 32'h0000_0110);
        wb_read("div3_t7", 3'd2, 32'h0000_0110);
        wb_read("div3_t9", 3'd2, 32'h0000_0210);
        wb_write(3'd1, 32'h4);

        // CONT, DIV=3: DATA3 pop coincides with the 9th push on a full FIFO,
        // then FLUSH coincides with the 10th
        la_data_in = pat(32'd500, 7);
        wb_write(3'd1, 32'h3);
        idle(34);
        wb_read("popfull_d3", 3'd7, 32'h3000_0007);
        wb_read("popfull_status", 3'd2, 32'h0000_0812);
        wb_write(3'd1, 32'h4);
        wb_read("flushwins_status", 3'd2, 32'h0000_0001);
        chk("popfull_irq", {127'd0, irq}, 128'd0);

        // CONT, DIV=0, no reads for 20 cycles: overflow, first 8 kept
        wb_write(3'd3, 32'd0);
        wb_write(3'd1, 32'h3);
        for (int n = 0; n < 20; n++) begin
            la_data_in = pat(32'd200, n);
            idle(1);
        end
        wb_read("ovf_status", 3'd2, 32'h0000_0816);
        chk("ovf_irq", {127'd0, irq}, {127'd0, c_IRQ_ON});
        wb_read("ovf_head_d0", 3'd4, 32'd200);
        wb_read("ovf_head_d1", 3'd5, 32'h1000_0000);
        wb_read("ovf_head_d2", 3'd6, 32'h2000_0000);
        wb_write(3'd1, 32'h4);
        wb_read("ovf_flush_status", 3'd2, 32'h0000_0001);
        idle(2);
        chk("ovf_flush_irq", {127'd0, irq}, 128'd0);

        // Reset in the middle of a capture
        wb_write(3'd3, 32'd1);
        wb_write(3'd1, 32'h1);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        wb_read("midrst_status", 3'd2, 32'h0000_0001);
        wb_read("midrst_div", 3'd3, 32'h0);
        chk("midrst_irq", {127'd0, irq}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/la_capture_wb.md
Name: la_capture_WB

Overview:
- Wishbone-slave block for the inbound direction of the logic analyzer (LA).
- Routes the management core's la_data_in to one selected team design.
- Captures 128-bit la_data_in samples into a small FIFO, which firmware reads back as 32-bit words over Wishbone.
- Sits beside the LA output mux on the same Wishbone bus and clock.

Parameters:
- NUM_TEAMS, 12: number of team designs; slots are indexed 0..NUM_TEAMS.
- FIFO_DEPTH, 8: capture FIFO entries; must be a power of 2, minimum 2.
- DIV_WIDTH, 16: width of the sample-period divider register.

Ports:
- wb_clk_i, input, 1: the only clock.
- wb_rst_i, input, 1: synchronous, active-high reset.
- wbs_stb_i, input, 1: Wishbone strobe.
- wbs_cyc_i, input, 1: Wishbone cycle.
- wbs_we_i, input, 1: write enable.
- wbs_sel_i, input, 4: byte selects.
- wbs_dat_i, input, 32: write data.
- wbs_adr_i, input, 32: address; only bits [4:2] are decoded.
- wbs_ack_o, output, 1: acknowledge.
- wbs_dat_o, output, 32: read data.
- la_data_in, input, 128: LA data from the management core.
- designs_la_data_in_flat, output, 128*(NUM_TEAMS+1): per-team LA input; slot k occupies bits [128k+127:128k].
- IRQ, output, 1: interrupt; see Optional Feature.

Behaviour:
- Reset values:
  - All outputs 0; all registers 0.
  - FIFO empty; state IDLE; sample counter 0.
- Wishbone handshake:
  - wbs_ack_o is registered.
  - It asserts one cycle after wbs_cyc_i & wbs_stb_i while ack is low, and stays high exactly one cycle.
  - The access (read or write) commits on the ack cycle.
  - wbs_dat_o is valid with ack and is 0 otherwise.
  - Byte lanes are honoured on writes to SEL, CTRL and DIV.
  - Unmapped reads return 0; unmapped writes are ignored.
- Register map (byte offset):
  - 0x00 SEL, RW: team slot index. Width $clog2(NUM_TEAMS+1).
  - 0x04 CTRL, W:
    - bit0 ARM: pulse; ignored unless IDLE or DONE.
    - bit1 CONT: stored; reads back at bit1.
    - bit2 FLUSH: pulse; empties the FIFO, clears OVF, forces state to IDLE.
  - 0x08 STATUS, RO:
    - bit0 empty; bit1 full; bit2 OVF (sticky).
    - bits[5:4] state (IDLE=0, CAPTURE=1, DONE=2).
    - bits[15:8] count.
  - 0x0C DIV, RW: sample period minus 1.
  - 0x10, 0x14, 0x18, 0x1C DATA0..DATA3, RO: words 0..3 of the FIFO head entry (DATA0 = bits[31:0]).
    - A read of DATA3 pops the head if the FIFO is non-empty.
    - Reads while empty return 0 and do not pop.
- Routing:
  - designs_la_data_in_flat slot SEL = la_data_in, registered with 1-cycle latency; all other slots 0.
  - SEL > NUM_TEAMS drives all slots to 0.
- Capture FSM:
  - IDLE:
    - ARM → CAPTURE; the sample counter loads 0.
  - CAPTURE:
    - Counter increments each cycle. When counter == DIV, la_data_in is pushed and the counter reloads 0, so the sample period is DIV+1 cycles (DIV=0 samples every cycle).
    - The first sample is taken the first cycle counter == DIV after entry.
    - One-shot (CONT=0): a push that makes the FIFO full → DONE.
    - Continuous (CONT=1): stays in CAPTURE. A push attempted while full is dropped and sets OVF.
  - DONE:
    - Holds; ARM re-enters CAPTURE.
- Simultaneous pop and push on a full FIFO: both occur, count is unchanged, no OVF.
- FLUSH in the same cycle as a push: FLUSH wins.
- Reset mid-capture: everything returns to reset values on the next edge.
- Count wraps never: it saturates structurally at FIFO_DEPTH.

Optional Feature:
- Macro: LA_CAPTURE_IRQ_EN.
- Defined:
  - IRQ is a registered level, high while (state == DONE) or OVF.
  - It clears via FLUSH or by popping out of DONE with ARM.
- Undefined: IRQ is tied to 0 and no IRQ logic is built.

Test Plan:
- Reset, then write SEL=3 and drive la_data_in = 0xA5…A5 → slot 3 carries 0xA5…A5 one cycle later; slots 0-2 and 4-12 are 0. Write SEL=13 → all slots 0.
- DIV=0, CONT=0, ARM with la_data_in incrementing by 1 each cycle → DONE after 8 pushes; STATUS shows full=1, count=8. DATA0 reads return 8 consecutive values.
- DIV=3, ARM → pushes exactly every 4 cycles, measured via count at known times.
- CONT=1, DIV=0, no reads for 20 cycles → count=8, OVF=1, FIFO contents are the first 8 samples. FLUSH → empty=1, OVF=0, state IDLE.
- Read DATA3 on an empty FIFO → returns 0, count stays 0. Read DATA3 while full in CONT mode with a simultaneous push → count stays 8, no OVF.
- With LA_CAPTURE_IRQ_EN: IRQ rises when DONE is entered and falls after FLUSH. Without the macro: IRQ stays 0 throughout.
